smg_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment scan driver, next generation of the fixed 4-digit board display driver. Scans DIGITS common-pin digits in time slots with a programmable dead time between slots, per-digit enable and PWM brightness. Frame-synchronous shadow loading removes tearing. Full 0-F hex decode and configurable pin polarity. Sits between application registers (counters, clock, debug values) and the board display pins.

---
 rtl/smg_pkg.sv | 49 ++++
 rtl/smg_hex_decode.sv | 14 +
 rtl/smg_scan_driver.sv | 212 +++++++++++++++++++++
 tb/tb_smg_scan_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared 7-segment constants and the nibble-to-segment helper for the smg display blocks.
// Segment order is {g,f,e,d,c,b,a}; all constants are active-high.
package smg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_HEX_0 = 7'h3F;
  localparam seg7_t SEG_HEX_1 = 7'h06;
  localparam seg7_t SEG_HEX_2 = 7'h5B;
  localparam seg7_t SEG_HEX_3 = 7'h4F;
  localparam seg7_t SEG_HEX_4 = 7'h66;
  localparam seg7_t SEG_HEX_5 = 7'h6D;
  localparam seg7_t SEG_HEX_6 = 7'h7D;
  localparam seg7_t SEG_HEX_7 = 7'h07;
  localparam seg7_t SEG_HEX_8 = 7'h7F;
  localparam seg7_t SEG_HEX_9 = 7'h6F;
  localparam seg7_t SEG_HEX_A = 7'h77;
  localparam seg7_t SEG_HEX_B = 7'h7C;
  localparam seg7_t SEG_HEX_C = 7'h39;
  localparam seg7_t SEG_HEX_D = 7'h5E;
  localparam seg7_t SEG_HEX_E = 7'h79;
  localparam seg7_t SEG_HEX_F = 7'h71;
  localparam seg7_t SEG_OFF   = 7'h00;

  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    seg7_t seg;
    case (nibble)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      4'hF:    seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/smg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module smg_hex_decode
  import smg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; polarity is applied by the caller.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/smg_scan_driver.sv
// Multiplexed 7-segment scan driver: slot timing, dead time, PWM brightness, frame-synchronous shadow load.
// Optional build macro SMG_LZ_BLANK_EN enables leading-zero suppression.
module smg_scan_driver
  import smg_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [3:0]            brightness,
  input  logic                  load,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            dig,
  output logic                  frame_done
);

  // Counter is at least 4 bits so the PWM compare always has slot_cnt[3:0].
  localparam int CNT_W = ($clog2(SCAN_DIV) < 4) ? 4 : $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  SLOT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        DIG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    scan_idx;

  logic [4*DIGITS-1:0] pend_digits;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_en;
  logic [3:0]          pend_bright;
  logic                pend_valid;

  logic [4*DIGITS-1:0] act_digits;
  logic [DIGITS-1:0]   act_dp;
  logic [DIGITS-1:0]   act_en;
  logic [3:0]          act_bright;

  logic                slot_wrap;
  logic                frame_end;
  logic [0:0]          state;
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_sup;
  logic [DIGITS-1:0]   cur_onehot;
  logic [DIGITS-1:0]   lz_mask;
  logic                bright_on;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   sel_hi;
  logic [7:0]          dig_hi;
  logic [DIGITS-1:0]   sel_next;
  logic [7:0]          dig_next;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_wrap && (scan_idx == IDX_LAST);

  // Slot counter and digit index; frame length is fixed regardless of enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      scan_idx <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      scan_idx <= frame_end ? '0 : scan_idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // Pending/active shadow pair; active only moves at the frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_bright <= 4'h0;
      pend_valid  <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      act_bright  <= 4'h0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_en     <= digit_en;
        pend_bright <= brightness;
      end
      if (frame_end) begin
        // A load on the boundary bypasses the pending stage entirely.
        if (load) begin
          act_digits <= digits_in;
          act_dp     <= dp_in;
          act_en     <= digit_en;
          act_bright <= brightness;
        end else if (pend_valid) begin
          act_digits <= pend_digits;
          act_dp     <= pend_dp;
          act_en     <= pend_en;
          act_bright <= pend_bright;
        end
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

`ifdef SMG_LZ_BLANK_EN
  logic lz_run;

  // Mark zero digits from the top down until the first nonzero; digit 0 is never marked.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lz_run && (act_digits[4*k +: 4] == 4'h0)) begin
        lz_mask[k] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end
`else
  // Suppression disabled: every enabled digit shows, leading zeros included.
  always_comb begin
    lz_mask = '0;
  end
`endif

  // Pick the active fields of the digit currently being scanned.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_sup    = 1'b0;
    cur_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        cur_nibble    = act_digits[4*k +: 4];
        cur_dp        = act_dp[k];
        cur_en        = act_en[k];
        cur_sup       = lz_mask[k];
        cur_onehot[k] = 1'b1;
      end else begin
        cur_onehot[k] = 1'b0;
      end
    end
  end

  smg_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (seg_raw)
  );

  // Slot phase, PWM gating and active-high pin values before polarity.
  always_comb begin
    state     = (slot_cnt < SLOT_BLANK) ? ST_BLANK : ST_SHOW;
    bright_on = (act_bright == 4'hF) || (slot_cnt[3:0] < act_bright);
    sel_hi    = '0;
    dig_hi    = 8'h00;
    case (state)
      ST_BLANK: begin
        sel_hi = '0;
        dig_hi = 8'h00;
      end
      ST_SHOW: begin
        // A suppressed digit stays dark unless its decimal point is set.
        if (cur_en && bright_on && (!cur_sup || cur_dp)) begin
          sel_hi = cur_onehot;
          dig_hi = {cur_dp, (cur_sup ? SEG_OFF : seg_raw)};
        end else begin
          sel_hi = '0;
          dig_hi = 8'h00;
        end
      end
      default: begin
        sel_hi = '0;
        dig_hi = 8'h00;
      end
    endcase
    sel_next = (SEL_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
    dig_next = (SEG_ACTIVE_LOW != 0) ? ~dig_hi : dig_hi;
  end

  // Registered pins, one clock behind the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel        <= SEL_OFF;
      dig        <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      sel        <= sel_next;
      dig        <= dig_next;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed table-driven bench: dut_a scans 4 digits x 8 cycles, dut_b 4 digits x 32 cycles (PWM).
module tb_smg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  brightness = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  sel_a, sel_b;
  logic [7:0]  dig_a, dig_b;
  logic        fd_a, fd_b;

  always #5 clk = ~clk;

  smg_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .digits_in(digits_in), .dp_in(dp_in), .digit_en(digit_en),
    .brightness(brightness), .load(load), .sel(sel_a), .dig(dig_a), .frame_done(fd_a));

  smg_scan_driver #(.DIGITS(4), .SCAN_DIV(32), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .digits_in(digits_in), .dp_in(dp_in), .digit_en(digit_en),
    .brightness(brightness), .load(load), .sel(sel_b), .dig(dig_b), .frame_done(fd_b));

  typedef struct {
    int         k;
    bit         dut;
    bit         rst;
    bit         ld;
    logic [15:0] d;
    logic [3:0] en;
    logic [3:0] br;
    logic [3:0] dp;
    bit         chk;
    logic [3:0] s;
    logic [7:0] g;
    bit         f;
  } vec_t;

  vec_t vt[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = -1;
  int   last_fd = -1;
  int   period = 32;
  bit   cur_dut = 1'b0;

  function automatic void add(bit dut, int k, bit rst, bit ld, logic [15:0] d, logic [3:0] en,
                              logic [3:0] br, logic [3:0] dp, bit chk, logic [3:0] s, logic [7:0] g, bit f);
    vec_t v;
    v.k = k; v.dut = dut; v.rst = rst; v.ld = ld; v.d = d; v.en = en; v.br = br; v.dp = dp;
    v.chk = chk; v.s = s; v.g = g; v.f = f;
    vt.push_back(v);
  endfunction

  // One clock; sample 1 time unit after the edge and check the generic invariants.
  task automatic step();
    logic [3:0] s;
    logic       f;
    @(posedge clk);
    #1;
    cyc++;
    s = cur_dut ? sel_b : sel_a;
    f = cur_dut ? fd_b : fd_a;
    total++;
    if ($countones(~s) > 1) begin
      bad++;
      $display("FAIL onehot dut%0d k=%0d: sel=%b, want at most one active bit", cur_dut, cyc, s);
    end
    if (f) begin
      if (last_fd >= 0) begin
        total++;
        if (cyc - last_fd != period) begin
          bad++;
          $display("FAIL fd_period dut%0d k=%0d: spacing=%0d, want %0d", cur_dut, cyc, cyc - last_fd, period);
        end
      end
      last_fd = cyc;
    end
  endtask

  task automatic cmp(string nm, bit dut, logic [3:0] s, logic [7:0] g, bit f);
    logic [3:0] as;
    logic [7:0] ag;
    logic       af;
    as = dut ? sel_b : sel_a;
    ag = dut ? dig_b : dig_a;
    af = dut ? fd_b : fd_a;
    total++;
    if ({as, ag, af} !== {s, g, f}) begin
      bad++;
      $display("FAIL %s dut%0d k=%0d: got sel=%h dig=%h fd=%b, want sel=%h dig=%h fd=%b",
               nm, dut, cyc, as, ag, af, s, g, f);
    end
  endtask

  initial begin
    int nlit;
    // dut_a: load 3A1F, shadowing, double load, boundary load, mid-show reset, leading zeros
    add(0,   0, 0, 1, 16'h3A1F, 4'hF, 4'hF, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  20, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  30, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  31, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 1);
    add(0,  32, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  33, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  34, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(0,  39, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(0,  40, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  42, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hD, 8'hF9, 0);
    add(0,  50, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hB, 8'h88, 0);
    add(0,  58, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'h7, 8'hB0, 0);
    add(0,  63, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'h7, 8'hB0, 1);
    add(0,  64, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  66, 0, 1, 16'h1111, 4'hF, 4'hF, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(0,  70, 0, 1, 16'h2222, 4'hF, 4'hF, 4'h0, 0, 4'h0, 8'h00, 0);
    add(0,  90, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'h7, 8'hB0, 0);
    add(0,  98, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'hA4, 0);
    add(0, 106, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hD, 8'hA4, 0);
    add(0, 127, 0, 1, 16'h5555, 4'hF, 4'hF, 4'h0, 1, 4'h7, 8'hA4, 1);
    add(0, 130, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h92, 0);
    add(0, 154, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'h7, 8'h92, 0);
    add(0, 160, 0, 1, 16'h9999, 4'hF, 4'hF, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0, 163, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h92, 0);
    add(0, 164, 1, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,   2, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  30, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  31, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 1);
    add(0,  34, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0,  40, 0, 1, 16'h3A1F, 4'hF, 4'hF, 4'h0, 0, 4'h0, 8'h00, 0);
    add(0,  66, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(0,  70, 0, 1, 16'h0040, 4'hF, 4'hF, 4'h0, 0, 4'h0, 8'h00, 0);
    add(0,  98, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'hC0, 0);
    add(0, 106, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hD, 8'h99, 0);
`ifdef SMG_LZ_BLANK_EN
    add(0, 114, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(0, 122, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
`else
    add(0, 114, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hB, 8'hC0, 0);
    add(0, 122, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'h7, 8'hC0, 0);
`endif
    // dut_b: brightness 4 PWM window, then enables 0101 with dp on digit 2
    add(1,   0, 0, 1, 16'h3A1F, 4'hF, 4'h4, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 127, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 1);
    add(1, 128, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 129, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 130, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(1, 131, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(1, 132, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 143, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 144, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(1, 147, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(1, 148, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 159, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 200, 0, 1, 16'h3A1F, 4'h5, 4'hF, 4'h4, 0, 4'h0, 8'h00, 0);
    add(1, 258, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hE, 8'h8E, 0);
    add(1, 290, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 322, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hB, 8'h08, 0);
    add(1, 354, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 0);
    add(1, 383, 0, 0, 16'h0,    4'h0, 4'h0, 4'h0, 1, 4'hF, 8'hFF, 1);

    // Reset state of both instances.
    repeat (3) step();
    cmp("reset_a", 1'b0, 4'hF, 8'hFF, 1'b0);
    cmp("reset_b", 1'b1, 4'hF, 8'hFF, 1'b0);
    rst_a = 1'b1;
    cyc = -1;

    foreach (vt[i]) begin
      if (vt[i].dut != cur_dut) begin
        rst_a = 1'b0;
        rst_b = 1'b1;
        cur_dut = 1'b1;
        period = 128;
        last_fd = -1;
        cyc = -1;
      end
      while (cyc < vt[i].k - 1) step();
      if (vt[i].rst) begin
        if (vt[i].dut) rst_b = 1'b0; else rst_a = 1'b0;
        step();
        cmp($sformatf("vec%0d_rst", i), vt[i].dut, vt[i].s, vt[i].g, vt[i].f);
        if (vt[i].dut) rst_b = 1'b1; else rst_a = 1'b1;
        cyc = -1;
        last_fd = -1;
      end else begin
        if (vt[i].ld) begin
          digits_in = vt[i].d;
          digit_en = vt[i].en;
          brightness = vt[i].br;
          dp_in = vt[i].dp;
          load = 1'b1;
        end
        step();
        load = 1'b0;
        if (vt[i].chk) cmp($sformatf("vec%0d", i), vt[i].dut, vt[i].s, vt[i].g, vt[i].f);
      end
    end

    // brightness 0: a whole frame of dut_b must stay dark.
    digits_in = 16'h3A1F;
    digit_en = 4'hF;
    brightness = 4'h0;
    dp_in = 4'h0;
    load = 1'b1;
    step();
    load = 1'b0;
    while (cyc < 511) step();
    nlit = 0;
    repeat (128) begin
      step();
      if (sel_b != 4'hF || dig_b != 8'hFF) nlit++;
    end
    total++;
    if (nlit != 0) begin
      bad++;
      $display("FAIL bright0_dark: lit cycles=%0d, want 0", nlit);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
